// File: rtl/bsg_cache_to_dram_ctrl_pkg.sv
// rtl/bsg_cache_to_dram_ctrl_pkg.sv - shared widths and error causes for the cache-to-DRAM rx/tx blocks
package bsg_cache_to_dram_ctrl_pkg;

  typedef enum logic [1:0] {
    e_overflow,
    e_orphan_data,
    e_tag_overrun
  } err_cause_e;

  localparam int num_err_causes_lp = 3;

  function automatic int lg(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int word_counter_width(input int block_size_in_words);
    return lg(block_size_in_words);
  endfunction

endpackage

// File: rtl/bsg_cache_to_dram_ctrl_rx_if.sv
// rtl/bsg_cache_to_dram_ctrl_rx_if.sv - request, read-beat and per-cache DMA signals of the rx path
interface bsg_cache_to_dram_ctrl_rx_if
  import bsg_cache_to_dram_ctrl_pkg::*;
#(
  parameter int num_cache_p  = 2,
  parameter int data_width_p = 32
) ();

  logic                                 v_i;
  logic [lg(num_cache_p)-1:0]           tag_i;
  logic                                 ready_o;
  logic                                 app_rd_data_valid_i;
  logic [data_width_p-1:0]              app_rd_data_i;
  logic                                 app_rd_data_end_i;
  logic [num_cache_p*data_width_p-1:0]  dma_data_o;
  logic [num_cache_p-1:0]               dma_data_v_o;
  logic [num_cache_p-1:0]               dma_data_ready_i;
  logic                                 error_o;

  modport master (
    output v_i, tag_i, app_rd_data_valid_i, app_rd_data_i, app_rd_data_end_i, dma_data_ready_i,
    input  ready_o, dma_data_o, dma_data_v_o, error_o
  );

  modport slave (
    input  v_i, tag_i, app_rd_data_valid_i, app_rd_data_i, app_rd_data_end_i, dma_data_ready_i,
    output ready_o, dma_data_o, dma_data_v_o, error_o
  );

endinterface

// File: rtl/bsg_cache_to_dram_ctrl_rx_sel.sv
// rtl/bsg_cache_to_dram_ctrl_rx_sel.sv - word counter, per-cache valid/ready steering and tag retire decision
module bsg_cache_to_dram_ctrl_rx_sel
  import bsg_cache_to_dram_ctrl_pkg::*;
#(
  parameter int num_cache_p           = 2,
  parameter int block_size_in_words_p = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       tag_v_i,
  input  logic [lg(num_cache_p)-1:0] tag_i,
  input  logic                       data_v_i,
  input  logic [num_cache_p-1:0]     dma_data_ready_i,
  output logic [num_cache_p-1:0]     dma_data_v_o,
  output logic                       xfer_o,
  output logic                       tag_yumi_o
);

  localparam int cnt_w_lp = word_counter_width(block_size_in_words_p);

  logic [cnt_w_lp-1:0] count;
  logic                avail;
  logic                last_word;

  assign avail     = tag_v_i & data_v_i;
  assign xfer_o    = avail & dma_data_ready_i[tag_i];
  assign last_word = (count == cnt_w_lp'(block_size_in_words_p - 1));
  assign tag_yumi_o = xfer_o & last_word;

  always_comb begin
    dma_data_v_o = '0;
    for (int i = 0; i < num_cache_p; i++) begin
      dma_data_v_o[i] = avail & (tag_i == lg(num_cache_p)'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count <= '0;
    end else if (xfer_o) begin
      count <= last_word ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// rtl/bsg_fifo_1r1w_small.sv - small registered FIFO; push and pop in one cycle both take effect even when full
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = (els_p <= 1) ? 1 : $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem [els_p];
  logic [ptr_w_lp-1:0] rptr, wptr;
  logic [cnt_w_lp-1:0] count;

  assign ready_o = (count != cnt_w_lp'(els_p));
  assign v_o     = (count != '0);
  assign data_o  = mem[rptr];

  function automatic logic [ptr_w_lp-1:0] ptr_next(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (v_i) mem[wptr] <= data_i;
  end

  // the caller gates v_i; a push into a full FIFO is only legal alongside a pop
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (v_i)    wptr <= ptr_next(wptr);
      if (yumi_i) rptr <= ptr_next(rptr);
      count <= count + cnt_w_lp'(v_i) - cnt_w_lp'(yumi_i);
    end
  end

endmodule

// File: rtl/bsg_cache_to_dram_ctrl_rx.sv
// rtl/bsg_cache_to_dram_ctrl_rx.sv - DRAM read-return path: tag FIFO + beat buffer steered to the requesting cache
// Optional sticky protocol error flag under BSG_CACHE_TO_DRAM_CTRL_RX_ERROR_CHECK_EN.
module bsg_cache_to_dram_ctrl_rx
  import bsg_cache_to_dram_ctrl_pkg::*;
#(
  parameter int num_cache_p           = 2,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 4,
  parameter int tag_fifo_els_p        = 8,
  parameter int data_fifo_els_p       = 8
) (
  input logic clk_i,
  input logic reset_i,
  bsg_cache_to_dram_ctrl_rx_if.slave io
);

  localparam int tag_w_lp = lg(num_cache_p);

  logic                    tag_v, tag_ready, tag_enq, tag_yumi;
  logic [tag_w_lp-1:0]     tag_head;
  logic                    data_v, data_ready, data_enq, xfer;
  logic [data_width_p-1:0] data_head;
  logic                    unused_app_rd_data_end;

  assign unused_app_rd_data_end = io.app_rd_data_end_i;

  assign io.ready_o = tag_ready;
  assign tag_enq    = io.v_i & tag_ready;
  // read beats cannot be stalled: accept when there is room now or a slot frees this edge
  assign data_enq   = io.app_rd_data_valid_i & (data_ready | xfer);

  bsg_fifo_1r1w_small #(.width_p(tag_w_lp), .els_p(tag_fifo_els_p)) tag_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (tag_enq),
    .data_i  (io.tag_i),
    .ready_o (tag_ready),
    .v_o     (tag_v),
    .data_o  (tag_head),
    .yumi_i  (tag_yumi)
  );

  bsg_fifo_1r1w_small #(.width_p(data_width_p), .els_p(data_fifo_els_p)) data_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (data_enq),
    .data_i  (io.app_rd_data_i),
    .ready_o (data_ready),
    .v_o     (data_v),
    .data_o  (data_head),
    .yumi_i  (xfer)
  );

  bsg_cache_to_dram_ctrl_rx_sel #(
    .num_cache_p           (num_cache_p),
    .block_size_in_words_p (block_size_in_words_p)
  ) sel (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .tag_v_i          (tag_v),
    .tag_i            (tag_head),
    .data_v_i         (data_v),
    .dma_data_ready_i (io.dma_data_ready_i),
    .dma_data_v_o     (io.dma_data_v_o),
    .xfer_o           (xfer),
    .tag_yumi_o       (tag_yumi)
  );

  assign io.dma_data_o = {num_cache_p{data_head}};

`ifdef BSG_CACHE_TO_DRAM_CTRL_RX_ERROR_CHECK_EN
  logic [num_err_causes_lp-1:0] err_cause;
  logic                         error_r;

  always_comb begin
    err_cause                = '0;
    err_cause[e_overflow]    = io.app_rd_data_valid_i & ~data_enq;
    err_cause[e_orphan_data] = io.app_rd_data_valid_i & ~tag_v & ~tag_enq;
    err_cause[e_tag_overrun] = io.v_i & ~tag_ready;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) error_r <= 1'b0;
    else         error_r <= error_r | (|err_cause);
  end

  assign io.error_o = error_r;
`else
  assign io.error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_cache_to_dram_ctrl_rx.sv
// tb/tb_bsg_cache_to_dram_ctrl_rx.sv - directed self-checking bench for bsg_cache_to_dram_ctrl_rx
module tb_bsg_cache_to_dram_ctrl_rx;

`ifdef BSG_CACHE_TO_DRAM_CTRL_RX_ERROR_CHECK_EN
  localparam logic exp_err = 1'b1;
`else
  localparam logic exp_err = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_i;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  bsg_cache_to_dram_ctrl_rx_if #(.num_cache_p(2), .data_width_p(32)) io ();

  bsg_cache_to_dram_ctrl_rx #(
    .num_cache_p           (2),
    .data_width_p          (32),
    .block_size_in_words_p (4),
    .tag_fifo_els_p        (8),
    .data_fifo_els_p       (8)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .io      (io)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] slice(input int i);
    return io.dma_data_o[i*32 +: 32];
  endfunction

  initial begin
    reset_i                = 1'b1;
    io.v_i                 = 1'b0;
    io.tag_i               = '0;
    io.app_rd_data_valid_i = 1'b0;
    io.app_rd_data_i       = '0;
    io.app_rd_data_end_i   = 1'b0;
    io.dma_data_ready_i    = 2'b00;
    cyc();
    cyc();
    reset_i = 1'b0;
    chk("reset_ready", 32'(io.ready_o), 32'd1);
    chk("reset_v", 32'(io.dma_data_v_o), 32'd0);
    chk("reset_err", 32'(io.error_o), 32'd0);

    // single block to cache 1
    io.dma_data_ready_i = 2'b10;
    io.v_i = 1'b1; io.tag_i = 1'b1;
    cyc();
    io.v_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      io.app_rd_data_valid_i = 1'b1;
      io.app_rd_data_i = 32'hA0 + 32'(k);
      if (k == 0) chk("single_no_bypass", 32'(io.dma_data_v_o), 32'd0);
      cyc();
      chk("single_v", 32'(io.dma_data_v_o), 32'b10);
      chk("single_data", slice(1), 32'hA0 + 32'(k));
    end
    io.app_rd_data_valid_i = 1'b0;
    cyc();
    chk("single_retired_v", 32'(io.dma_data_v_o), 32'd0);
    chk("single_err", 32'(io.error_o), 32'd0);

    // interleaved tags 0,1,0
    io.dma_data_ready_i = 2'b11;
    io.v_i = 1'b1;
    io.tag_i = 1'b0; cyc();
    io.tag_i = 1'b1; cyc();
    io.tag_i = 1'b0; cyc();
    io.v_i = 1'b0;
    for (int k = 0; k < 12; k++) begin
      int c;
      c = (k >= 4 && k < 8) ? 1 : 0;
      io.app_rd_data_valid_i = 1'b1;
      io.app_rd_data_i = 32'(k);
      cyc();
      chk("inter_v", 32'(io.dma_data_v_o), 32'(1 << c));
      chk("inter_data", slice(c), 32'(k));
    end
    io.app_rd_data_valid_i = 1'b0;
    cyc();
    chk("inter_done_v", 32'(io.dma_data_v_o), 32'd0);

    // back-pressure on cache 0
    io.dma_data_ready_i = 2'b00;
    io.v_i = 1'b1; io.tag_i = 1'b0;
    cyc();
    io.v_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      io.app_rd_data_valid_i = (k < 4);
      io.app_rd_data_i = 32'hA0 + 32'(k);
      cyc();
      chk("bp_hold_v", 32'(io.dma_data_v_o), 32'b01);
      chk("bp_hold_data", slice(0), 32'hA0);
    end
    io.app_rd_data_valid_i = 1'b0;
    io.dma_data_ready_i = 2'b01;
    for (int k = 0; k < 4; k++) begin
      chk("bp_drain_data", slice(0), 32'hA0 + 32'(k));
      cyc();
    end
    chk("bp_done_v", 32'(io.dma_data_v_o), 32'd0);
    chk("bp_err", 32'(io.error_o), 32'd0);

    // overflow: 9 beats into an 8-entry buffer
    io.dma_data_ready_i = 2'b00;
    io.v_i = 1'b1; io.tag_i = 1'b0;
    cyc();
    cyc();
    io.v_i = 1'b0;
    for (int k = 0; k < 9; k++) begin
      io.app_rd_data_valid_i = 1'b1;
      io.app_rd_data_i = 32'hB0 + 32'(k);
      if (k == 8) chk("ovf_err_before", 32'(io.error_o), 32'd0);
      cyc();
    end
    io.app_rd_data_valid_i = 1'b0;
    chk("ovf_err", 32'(io.error_o), 32'(exp_err));
    chk("ovf_head", slice(0), 32'hB0);
    io.dma_data_ready_i = 2'b01;
    for (int k = 0; k < 8; k++) begin
      chk("ovf_drain_data", slice(0), 32'hB0 + 32'(k));
      cyc();
    end
    chk("ovf_dropped_v", 32'(io.dma_data_v_o), 32'd0);
    chk("ovf_err_sticky", 32'(io.error_o), 32'(exp_err));
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    chk("ovf_reset_err", 32'(io.error_o), 32'd0);

    // tag FIFO full, overrun, then reset mid-block
    io.dma_data_ready_i = 2'b00;
    for (int k = 0; k < 8; k++) begin
      io.v_i = 1'b1; io.tag_i = 1'(k);
      chk("tagfill_ready", 32'(io.ready_o), 32'd1);
      cyc();
    end
    chk("tagfull_ready", 32'(io.ready_o), 32'd0);
    io.tag_i = 1'b1;
    chk("tagfull_err_before", 32'(io.error_o), 32'd0);
    cyc();
    io.v_i = 1'b0;
    chk("overrun_err", 32'(io.error_o), 32'(exp_err));
    chk("overrun_ready", 32'(io.ready_o), 32'd0);
    io.app_rd_data_valid_i = 1'b1; io.app_rd_data_i = 32'hC0;
    cyc();
    io.app_rd_data_valid_i = 1'b0;
    chk("midblk_v", 32'(io.dma_data_v_o), 32'b01);
    chk("midblk_data", slice(0), 32'hC0);
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    chk("midrst_ready", 32'(io.ready_o), 32'd1);
    chk("midrst_v", 32'(io.dma_data_v_o), 32'd0);
    chk("midrst_err", 32'(io.error_o), 32'd0);

    // orphan beat buffered until its tag arrives
    io.dma_data_ready_i = 2'b11;
    io.app_rd_data_valid_i = 1'b1; io.app_rd_data_i = 32'h55;
    cyc();
    io.app_rd_data_valid_i = 1'b0;
    chk("orphan_v", 32'(io.dma_data_v_o), 32'd0);
    chk("orphan_err", 32'(io.error_o), 32'(exp_err));
    cyc();
    cyc();
    io.v_i = 1'b1; io.tag_i = 1'b1;
    chk("orphan_wait_v", 32'(io.dma_data_v_o), 32'd0);
    cyc();
    io.v_i = 1'b0;
    chk("orphan_deliver_v", 32'(io.dma_data_v_o), 32'b10);
    chk("orphan_deliver_data", slice(1), 32'h55);
    cyc();
    chk("orphan_done_v", 32'(io.dma_data_v_o), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
